// File: rtl/regfile_loader.sv
`default_nettype none
// ============================================================================
// Module      : regfile_loader
// Description : Owns the register-file MAU port while the CPU is halted; bulk
//               clears or stream-loads all registers, then releases the CPU.
// Revision    : 1.0
// ============================================================================
module regfile_loader #(
    parameter int NUM_REGS = 32,
    parameter int IDX_W    = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cmd_clear,
    input  logic             cmd_load,
    input  logic             cmd_run,
    input  logic             halt,
    input  logic [31:0]      in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [31:0]      mau_address,
    output logic [31:0]      mau_data_write,
    output logic             mau_wren,
    output logic             mau_clk_en,
    output logic             alive,
    output logic             busy,
    output logic [IDX_W:0]   load_count
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_LOAD  = 3'd2,
        S_FLUSH = 3'd3,
        S_RUN   = 3'd4
    } state_t;

    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NUM_REGS - 1);
    localparam logic [IDX_W:0]   c_num_regs = (IDX_W + 1)'(NUM_REGS);

    state_t             r_state, w_state_nxt;
    logic [IDX_W-1:0]   r_idx, w_idx_nxt;
    logic [IDX_W:0]     r_load_count, w_load_count_nxt;
    logic               r_wren, w_wren_nxt;
    logic [31:0]        r_addr, w_addr_nxt;
    logic [31:0]        r_data, w_data_nxt;
    logic               r_alive, w_alive_nxt;

    logic               w_xfer;
    logic               w_idx_last;
    logic [IDX_W-1:0]   w_idx_inc;
    logic [31:0]        w_idx_addr;

    assign w_xfer     = (r_state == S_LOAD) && in_valid;
    assign w_idx_last = (r_idx == c_last_idx);
    assign w_idx_inc  = w_idx_last ? r_idx : r_idx + IDX_W'(1);
    assign w_idx_addr = {{(30 - IDX_W){1'b0}}, r_idx, 2'b00};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_idx        <= '0;
            r_load_count <= '0;
            r_wren       <= 1'b0;
            r_addr       <= '0;
            r_data       <= '0;
            r_alive      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_idx        <= w_idx_nxt;
            r_load_count <= w_load_count_nxt;
            r_wren       <= w_wren_nxt;
            r_addr       <= w_addr_nxt;
            r_data       <= w_data_nxt;
            r_alive      <= w_alive_nxt;
        end
    end

    // Bus outputs are registered: the write for the current idx lands next cycle.
    always_comb begin
        w_state_nxt      = r_state;
        w_idx_nxt        = r_idx;
        w_load_count_nxt = r_load_count;
        w_wren_nxt       = 1'b0;
        w_addr_nxt       = '0;
        w_data_nxt       = '0;
        w_alive_nxt      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cmd_clear) begin
                    w_state_nxt = S_CLEAR;
                    w_idx_nxt   = '0;
                end else if (cmd_load) begin
                    w_state_nxt      = S_LOAD;
                    w_idx_nxt        = '0;
                    w_load_count_nxt = '0;
                end else if (cmd_run) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_CLEAR: begin
                w_wren_nxt = 1'b1;
                w_addr_nxt = w_idx_addr;
                if (w_idx_last) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_idx_nxt = w_idx_inc;
                end
            end
            S_LOAD: begin
                if (w_xfer) begin
                    w_wren_nxt = 1'b1;
                    w_addr_nxt = w_idx_addr;
                    w_data_nxt = in_data;
                    if (r_load_count != c_num_regs) begin
                        w_load_count_nxt = r_load_count + (IDX_W + 1)'(1);
                    end
                    if (w_idx_last) begin
                        w_state_nxt = S_FLUSH;
                    end else begin
                        w_idx_nxt = w_idx_inc;
                    end
                end
            end
            S_FLUSH: begin
                w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (halt) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_alive_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign in_ready       = (r_state == S_LOAD);
    assign busy           = (r_state == S_CLEAR) || (r_state == S_LOAD) || (r_state == S_FLUSH);
    assign mau_address    = r_addr;
    assign mau_data_write = r_data;
    assign mau_wren       = r_wren;
    assign mau_clk_en     = r_wren;
    assign alive          = r_alive;
    assign load_count     = r_load_count;

endmodule
`default_nettype wire

// File: tb/tb_regfile_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_loader
// Description : Directed self-checking bench for regfile_loader.
// Revision    : 1.0
// ============================================================================
module tb_regfile_loader;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_clear, cmd_load, cmd_run, halt;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] mau_address, mau_data_write;
    logic        mau_wren, mau_clk_en, alive, busy;
    logic [5:0]  load_count;

    int n_cmp  = 0;
    int n_fail = 0;
    int wr_seen;

    always #5 clk = ~clk;

    regfile_loader #(.NUM_REGS(32), .IDX_W(5)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .cmd_clear      (cmd_clear),
        .cmd_load       (cmd_load),
        .cmd_run        (cmd_run),
        .halt           (halt),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .mau_address    (mau_address),
        .mau_data_write (mau_data_write),
        .mau_wren       (mau_wren),
        .mau_clk_en     (mau_clk_en),
        .alive          (alive),
        .busy           (busy),
        .load_count     (load_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n   = 1'b0;
        cmd_clear = 1'b0;
        cmd_load  = 1'b0;
        cmd_run   = 1'b0;
        halt      = 1'b0;
        in_data   = 32'h0;
        in_valid  = 1'b0;
        tick();
        tick();
        chk("rst_alive",    32'(alive),          32'd0);
        chk("rst_in_ready", 32'(in_ready),       32'd0);
        chk("rst_wren",     32'(mau_wren),       32'd0);
        chk("rst_clk_en",   32'(mau_clk_en),     32'd0);
        chk("rst_addr",     mau_address,         32'd0);
        chk("rst_data",     mau_data_write,      32'd0);
        chk("rst_busy",     32'(busy),           32'd0);
        chk("rst_lcount",   32'(load_count),     32'd0);
        reset_n = 1'b1;

        // Bulk clear
        cmd_clear = 1'b1;
        tick();
        cmd_clear = 1'b0;
        chk("clr_busy0", 32'(busy),     32'd1);
        chk("clr_wren0", 32'(mau_wren), 32'd0);
        for (int i = 0; i < 32; i++) begin
            tick();
            chk("clr_wren",   32'(mau_wren),   32'd1);
            chk("clr_clk_en", 32'(mau_clk_en), 32'd1);
            chk("clr_addr",   mau_address,     32'(i * 4));
            chk("clr_data",   mau_data_write,  32'd0);
        end
        chk("clr_busy_end", 32'(busy), 32'd0);
        tick();
        chk("clr_wren_end",  32'(mau_wren), 32'd0);
        chk("clr_busy_idle", 32'(busy),     32'd0);
        chk("clr_alive",     32'(alive),    32'd0);

        // Back-to-back load
        cmd_load = 1'b1;
        tick();
        cmd_load = 1'b0;
        chk("ld_ready",  32'(in_ready),   32'd1);
        chk("ld_lcount", 32'(load_count), 32'd0);
        in_valid = 1'b1;
        for (int i = 0; i < 32; i++) begin
            in_data = 32'h1000 + 32'(i);
            tick();
            chk("ld_wren",   32'(mau_wren),   32'd1);
            chk("ld_addr",   mau_address,     32'(i * 4));
            chk("ld_data",   mau_data_write,  32'h1000 + 32'(i));
            chk("ld_lcount", 32'(load_count), 32'(i + 1));
        end
        chk("flush_ready", 32'(in_ready), 32'd0);
        chk("flush_busy",  32'(busy),     32'd1);
        in_valid = 1'b0;
        tick();
        chk("run_entry_wren",  32'(mau_wren), 32'd0);
        chk("run_entry_alive", 32'(alive),    32'd0);
        chk("run_entry_busy",  32'(busy),     32'd0);
        tick();
        chk("run_alive",  32'(alive),      32'd1);
        chk("run_lcount", 32'(load_count), 32'd32);
        chk("run_wren",   32'(mau_wren),   32'd0);

        // Commands ignored in RUN; halt and re-run
        cmd_clear = 1'b1;
        tick();
        cmd_clear = 1'b0;
        chk("run_cmd_alive", 32'(alive), 32'd1);
        chk("run_cmd_busy",  32'(busy),  32'd0);
        tick();
        chk("run_cmd_wren", 32'(mau_wren), 32'd0);
        halt = 1'b1;
        tick();
        halt = 1'b0;
        chk("halt_alive", 32'(alive), 32'd0);
        cmd_run = 1'b1;
        tick();
        cmd_run = 1'b0;
        chk("rerun_alive0", 32'(alive),    32'd0);
        chk("rerun_wren0",  32'(mau_wren), 32'd0);
        tick();
        chk("rerun_alive1", 32'(alive),    32'd1);
        chk("rerun_wren1",  32'(mau_wren), 32'd0);
        halt = 1'b1;
        tick();
        halt = 1'b0;

        // Load with gaps
        cmd_load = 1'b1;
        tick();
        cmd_load = 1'b0;
        wr_seen = 0;
        for (int i = 0; i < 32; i++) begin
            in_valid = 1'b1;
            in_data  = 32'h2000 + 32'(i);
            tick();
            if (mau_wren) wr_seen++;
            chk("gap_wren", 32'(mau_wren),  32'd1);
            chk("gap_addr", mau_address,    32'(i * 4));
            chk("gap_data", mau_data_write, 32'h2000 + 32'(i));
            in_valid = 1'b0;
            in_data  = 32'hDEAD0000 + 32'(i);
            tick();
            if (mau_wren) wr_seen++;
            chk("gap_idle_wren", 32'(mau_wren),   32'd0);
            chk("gap_lcount",    32'(load_count), 32'(i + 1));
        end
        chk("gap_total", 32'(wr_seen), 32'd32);
        tick();
        chk("gap_alive", 32'(alive), 32'd1);
        halt = 1'b1;
        tick();
        halt = 1'b0;

        // Command priority and dropped command during CLEAR
        cmd_clear = 1'b1;
        cmd_load  = 1'b1;
        cmd_run   = 1'b1;
        tick();
        cmd_clear = 1'b0;
        cmd_load  = 1'b0;
        cmd_run   = 1'b0;
        chk("pri_busy",   32'(busy),       32'd1);
        chk("pri_ready",  32'(in_ready),   32'd0);
        chk("pri_lcount", 32'(load_count), 32'd32);
        for (int i = 0; i < 32; i++) begin
            if (i == 5) cmd_load = 1'b1;
            tick();
            cmd_load = 1'b0;
            chk("pri_wren",  32'(mau_wren),  32'd1);
            chk("pri_addr",  mau_address,    32'(i * 4));
            chk("pri_data",  mau_data_write, 32'd0);
            chk("pri_ready", 32'(in_ready),  32'd0);
        end
        chk("pri_busy_end", 32'(busy), 32'd0);
        tick();
        chk("pri_wren_end", 32'(mau_wren), 32'd0);
        chk("pri_idle_rdy", 32'(in_ready), 32'd0);
        chk("pri_alive",    32'(alive),    32'd0);
        tick();
        chk("pri_drop_rdy", 32'(in_ready), 32'd0);
        chk("pri_drop_bsy", 32'(busy),     32'd0);

        // Reset mid-load, then restart
        cmd_load = 1'b1;
        tick();
        cmd_load = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_data = 32'h3000 + 32'(i);
            tick();
            chk("abort_addr",   mau_address,     32'(i * 4));
            chk("abort_data",   mau_data_write,  32'h3000 + 32'(i));
            chk("abort_lcount", 32'(load_count), 32'(i + 1));
        end
        reset_n = 1'b0;
        #1;
        chk("arst_wren",   32'(mau_wren),   32'd0);
        chk("arst_clk_en", 32'(mau_clk_en), 32'd0);
        chk("arst_addr",   mau_address,     32'd0);
        chk("arst_data",   mau_data_write,  32'd0);
        chk("arst_ready",  32'(in_ready),   32'd0);
        chk("arst_busy",   32'(busy),       32'd0);
        chk("arst_lcount", 32'(load_count), 32'd0);
        chk("arst_alive",  32'(alive),      32'd0);
        in_valid = 1'b0;
        #2;
        reset_n = 1'b1;
        tick();
        chk("post_rst_ready", 32'(in_ready), 32'd0);
        chk("post_rst_busy",  32'(busy),     32'd0);
        cmd_load = 1'b1;
        tick();
        cmd_load = 1'b0;
        chk("reload_ready",  32'(in_ready),   32'd1);
        chk("reload_lcount", 32'(load_count), 32'd0);
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 32'h4000 + 32'(i);
            tick();
            chk("reload_wren",   32'(mau_wren),   32'd1);
            chk("reload_addr",   mau_address,     32'(i * 4));
            chk("reload_data",   mau_data_write,  32'h4000 + 32'(i));
            chk("reload_lcount", 32'(load_count), 32'(i + 1));
        end
        in_valid = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
